// File: rtl/rv_pkg.sv
// Shared register-file writeback types and widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // One register-file write request: destination index plus data.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wdata;
    } wb_req_t;

endpackage : rv_pkg

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a flat view of every slot for associative lookups.
// Latency: pushed data is visible at head the cycle after the push edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (empties the FIFO)
//   push, push_data     write one entry
//   pop                 discard the head entry
//   full, empty, head   status and current head entry
//   ent_valid[i]        physical slot i holds a live entry
//   ent_data            slot i occupies ent_data[i*WIDTH +: WIDTH]
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [WIDTH-1:0]       head,
    output logic [DEPTH-1:0]       ent_valid,
    output logic [DEPTH*WIDTH-1:0] ent_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    // One extra bit so that DEPTH itself is representable (full vs empty).
    logic [AW:0]      count;

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; liveness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        logic [AW-1:0] offs;
        assign offs                        = AW'(i) - rd_ptr;
        assign ent_valid[i]                = ({1'b0, offs} < count);
        assign ent_data[i*WIDTH +: WIDTH]  = mem[i];
    end

endmodule : sync_fifo

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port between pipeline writeback (A) and a multi-cycle unit (B).
// Latency: 0 cycles for A and bypassed B; queued B writes at the first cycle with no A claim, in order.
// Backpressure: A is never stalled; B sees b_ready=0 only when the queue is full; stall_req asks for a bubble when B starves.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   a_valid, a_rd, a_wdata       pipeline writeback (always consumed)
//   b_valid, b_ready, b_rd, b_wdata   multi-cycle result, valid/ready
//   rs1, rs2, rs1_pend, rs2_pend decode sources and their match against queued B destinations
//   stall_req                    registered request for a writeback bubble
//   rf_en, rf_rd, rf_wdata       register-file write port
module rf_wb_arbiter
    import rv_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [REG_AW-1:0] a_rd,
    input  logic [XLEN-1:0]   a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_rd,
    input  logic [XLEN-1:0]   b_wdata,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              rs1_pend,
    output logic              rs2_pend,
    output logic              stall_req,
    output logic              rf_en,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wdata
);

    localparam int WBW = $bits(wb_req_t);
    localparam int CW  = $clog2(STARVE_MAX + 1);

    wb_req_t              q_head;
    wb_req_t              q_push_data;
    logic                 q_full;
    logic                 q_empty;
    logic                 q_push;
    logic                 q_pop;
    logic [DEPTH-1:0]     q_valid;
    logic [DEPTH*WBW-1:0] q_data;

    logic                 a_claim;
    logic                 b_bypass;
    logic [CW-1:0]        starve_cnt;

    // ------------------------------------------------------------------
    // Port grant: A (non-x0) > queue head > direct B bypass.
    // Nothing is granted during reset so A cannot write while rst=1.
    // ------------------------------------------------------------------
    assign a_claim  = !rst && a_valid && (a_rd != '0);
    assign q_pop    = !rst && !a_claim && !q_empty;
    // Bypass only with an empty queue so older queued results keep their order.
    assign b_bypass = !rst && !a_claim && q_empty && b_valid && (b_rd != '0);

    // A full queue refuses B even if its head drains this cycle; the
    // bypass term only matters when the queue is empty, i.e. never full.
    assign b_ready  = !rst && (!q_full || b_bypass);

    // x0 results are accepted and simply dropped.
    assign q_push      = b_valid && b_ready && (b_rd != '0) && !b_bypass;
    assign q_push_data = '{rd: b_rd, wdata: b_wdata};

    always_comb begin
        rf_en    = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        if (a_claim) begin
            rf_en    = 1'b1;
            rf_rd    = a_rd;
            rf_wdata = a_wdata;
        end else if (q_pop) begin
            rf_en    = 1'b1;
            rf_rd    = q_head.rd;
            rf_wdata = q_head.wdata;
        end else if (b_bypass) begin
            rf_en    = 1'b1;
            rf_rd    = b_rd;
            rf_wdata = b_wdata;
        end
    end

    sync_fifo #(
        .WIDTH (WBW),
        .DEPTH (DEPTH)
    ) u_bq (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head),
        .ent_valid (q_valid),
        .ent_data  (q_data)
    );

    // ------------------------------------------------------------------
    // Pending-destination compare against every live queue entry.
    // Bypassed writes land this cycle and are never reported.
    // ------------------------------------------------------------------
    wb_req_t q_ent [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
        assign q_ent[i] = q_data[i*WBW +: WBW];
    end

    always_comb begin
        rs1_pend = 1'b0;
        rs2_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (q_ent[i].rd == rs1) && (rs1 != '0)) begin
                rs1_pend = 1'b1;
            end
            if (q_valid[i] && (q_ent[i].rd == rs2) && (rs2 != '0)) begin
                rs2_pend = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation tracking. With a non-empty queue, any cycle without a
    // pop is a cycle A held the port. stall_req follows the saturated
    // counter by one cycle and holds until the cycle after a pop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            if (q_pop || q_empty) begin
                starve_cnt <= '0;
            end else if (a_claim && (starve_cnt != CW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (q_pop) begin
                stall_req <= 1'b0;
            end else if (starve_cnt == CW'(STARVE_MAX)) begin
                stall_req <= 1'b1;
            end
        end
    end

endmodule : rf_wb_arbiter
